// File: rtl/ssg_scan_control_if.sv
// Signal bundle between the game FSM and the seven-segment scan controller.
// The game side drives the score pulses and game-over level; the controller returns the pin drives and the score.
interface ssg_scan_control_if;
  logic        ssg_scan_control_inc;
  logic        ssg_scan_control_clear;
  logic        ssg_scan_control_game_over;
  logic [7:0]  ssg_scan_control_anode;
  logic [6:0]  ssg_scan_control_cathodes;
  logic [15:0] ssg_scan_control_score;

  modport master (
    output ssg_scan_control_inc, ssg_scan_control_clear, ssg_scan_control_game_over,
    input  ssg_scan_control_anode, ssg_scan_control_cathodes, ssg_scan_control_score
  );

  modport slave (
    input  ssg_scan_control_inc, ssg_scan_control_clear, ssg_scan_control_game_over,
    output ssg_scan_control_anode, ssg_scan_control_cathodes, ssg_scan_control_score
  );
endinterface

// File: rtl/ssg_scan_control.sv
// Score/high-score BCD counters multiplexed onto an 8-digit common-anode display.
// Leading zeros are blanked per 4-digit group, and the display blinks while game over.
module ssg_scan_control #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_TICKS = 250
) (
  input  logic              ssg_scan_control_clk,
  input  logic              ssg_scan_control_rst,
  ssg_scan_control_if.slave bus
);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_TICKS + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(REFRESH_DIV - 1);
  localparam logic [BW-1:0] BLINK_MAX = BW'(BLINK_TICKS - 1);

  typedef enum logic {BLINK_ON, BLINK_OFF} blink_e;

  logic [15:0]   score;
  logic [15:0]   hi;
  logic          go_prev;
  logic [PW-1:0] presc;
  logic [2:0]    idx;
  logic          tick;
  blink_e        blink_state;
  blink_e        blink_next;
  logic [BW-1:0] blink_cnt;
  logic [BW-1:0] blink_cnt_next;
  logic          show;
  logic [15:0]   grp;
  logic [3:0]    nib;
  logic          blank;
  logic [6:0]    seg;
  logic [7:0]    anode;
  logic [6:0]    cathodes;

  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b0000001;
      4'd1:    return 7'b1001111;
      4'd2:    return 7'b0010010;
      4'd3:    return 7'b0000110;
      4'd4:    return 7'b1001100;
      4'd5:    return 7'b0100100;
      4'd6:    return 7'b0100000;
      4'd7:    return 7'b0001111;
      4'd8:    return 7'b0000000;
      4'd9:    return 7'b0000100;
      default: return 7'h7F;
    endcase
  endfunction

  assign tick = (presc == PRESC_MAX);

  // The high-score compare sees the score register before this cycle's inc lands.
  always_ff @(posedge ssg_scan_control_clk) begin
    if (ssg_scan_control_rst) begin
      score   <= '0;
      hi      <= '0;
      go_prev <= 1'b0;
    end else begin
      go_prev <= bus.ssg_scan_control_game_over;
      if (bus.ssg_scan_control_game_over && !go_prev && (score > hi))
        hi <= score;
      if (bus.ssg_scan_control_clear)
        score <= '0;
      else if (bus.ssg_scan_control_inc && (score != 16'h9999))
        score <= bcd_inc(score);
    end
  end

  always_ff @(posedge ssg_scan_control_clk) begin
    if (ssg_scan_control_rst) begin
      presc <= '0;
      idx   <= '0;
    end else if (tick) begin
      presc <= '0;
      idx   <= idx + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

  always_ff @(posedge ssg_scan_control_clk) begin
    if (ssg_scan_control_rst) begin
      blink_state <= BLINK_ON;
      blink_cnt   <= '0;
    end else begin
      blink_state <= blink_next;
      blink_cnt   <= blink_cnt_next;
    end
  end

  always_comb begin
    blink_next     = blink_state;
    blink_cnt_next = blink_cnt;
    if (!bus.ssg_scan_control_game_over) begin
      blink_next     = BLINK_ON;
      blink_cnt_next = '0;
    end else if (tick) begin
      if (blink_cnt == BLINK_MAX) begin
        blink_next     = (blink_state == BLINK_ON) ? BLINK_OFF : BLINK_ON;
        blink_cnt_next = '0;
      end else begin
        blink_cnt_next = blink_cnt + 1'b1;
      end
    end
  end

  // Dropping game_over forces ON immediately so no dark slot lingers afterwards.
  always_comb begin
    show = 1'b1;
    if (bus.ssg_scan_control_game_over)
      show = (blink_state == BLINK_ON);
  end

  always_comb begin
    grp = idx[2] ? hi : score;
    nib = grp[{idx[1:0], 2'b00} +: 4];
    case (idx[1:0])
      2'd1:    blank = (grp[15:4] == 12'h000);
      2'd2:    blank = (grp[15:8] == 8'h00);
      2'd3:    blank = (grp[15:12] == 4'h0);
      default: blank = 1'b0;
    endcase
    seg = blank ? 7'h7F : seg_decode(nib);
  end

  // Anode and cathodes share one register stage so they always change on the same edge.
  always_ff @(posedge ssg_scan_control_clk) begin
    if (ssg_scan_control_rst) begin
      anode    <= 8'hFF;
      cathodes <= 7'h7F;
    end else if (tick) begin
      anode    <= show ? ~(8'd1 << idx) : 8'hFF;
      cathodes <= seg;
    end
  end

  assign bus.ssg_scan_control_anode    = anode;
  assign bus.ssg_scan_control_cathodes = cathodes;
  assign bus.ssg_scan_control_score    = score;
endmodule
